// File: rtl/thor2021_pkg.sv
// thor2021_pkg
//   Shared definitions for the Thor2021 decode queue: the Instruction type,
//   the queue entry record, opcode constants for the immediate-carrying
//   instructions and the EXI7/EXI23/EXI41 postfixes, the head-action
//   encoding used by the queue, and opcode classification helpers.
//   The opcode occupies ir[6:0].
package thor2021_pkg;

  typedef logic [47:0] Instruction;
  typedef logic [6:0]  Opcode;

  typedef struct packed {
    Instruction  ir;
    logic [63:0] pc;
  } DecodeQEntry;

  // What the queue head does in a cycle where the output register can load.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_ORPHAN,
    ACT_FUSE,
    ACT_WAIT,
    ACT_SINGLE
  } HeadAction;

  // Short-immediate forms (imm in ir[19:9])
  localparam Opcode ADDI  = 7'h04;
  localparam Opcode SUBFI = 7'h05;
  localparam Opcode CMPI  = 7'h06;
  localparam Opcode ANDI  = 7'h08;
  localparam Opcode ORI   = 7'h09;
  localparam Opcode XORI  = 7'h0A;
  localparam Opcode SEQI  = 7'h0C;
  localparam Opcode SNEI  = 7'h0D;
  localparam Opcode SLTI  = 7'h0E;

  // Long-immediate forms (imm in ir[43:21])
  localparam Opcode ADDIL = 7'h14;
  localparam Opcode CMPIL = 7'h16;
  localparam Opcode ANDIL = 7'h18;
  localparam Opcode ORIL  = 7'h19;
  localparam Opcode XORIL = 7'h1A;
  localparam Opcode SEQIL = 7'h1C;
  localparam Opcode SNEIL = 7'h1D;
  localparam Opcode SLTIL = 7'h1E;

  // Immediate-extension postfixes
  localparam Opcode EXI7  = 7'h48;
  localparam Opcode EXI23 = 7'h49;
  localparam Opcode EXI41 = 7'h4A;

  function automatic Opcode opcode_of(input Instruction ir);
    return ir[6:0];
  endfunction

  function automatic logic is_long_imm(input Opcode op);
    return op inside {ADDIL, CMPIL, SEQIL, SNEIL, SLTIL, ANDIL, ORIL, XORIL};
  endfunction

  function automatic logic is_postfix(input Opcode op);
    return op inside {EXI7, EXI23, EXI41};
  endfunction

endpackage

// File: rtl/thor2021_imm_fuse.sv
// thor2021_imm_fuse
//   Combinational immediate builder for the decode queue head.
//   Ports:
//     ir_i    head instruction
//     pfx_i   instruction in the slot after the head (postfix candidate)
//     fuse_i  1: build the extended immediate from ir_i + pfx_i
//             0: build the unextended immediate from ir_i alone
//     imm_o   64-bit immediate; 0 for opcodes that carry none (incl. postfixes)
module thor2021_imm_fuse
  import thor2021_pkg::*;
(
  input  Instruction  ir_i,
  input  Instruction  pfx_i,
  input  logic        fuse_i,
  output logic [63:0] imm_o
);

  // Fields not used by any immediate form.
  logic unused_bits;
  assign unused_bits = ^{ir_i[47:44], ir_i[20], ir_i[8:7], pfx_i[8:7]};

  always_comb begin
    imm_o = '0;
    if (fuse_i) begin
      case (opcode_of(pfx_i))
        EXI7:    imm_o = {{34{pfx_i[15]}}, pfx_i[15:9], ir_i[43:21]};
        EXI23:   imm_o = {{18{pfx_i[31]}}, pfx_i[31:9], ir_i[43:21]};
        EXI41:   imm_o = {pfx_i[47:9], ir_i[43:21], pfx_i[1:0]};
        default: imm_o = '0;
      endcase
    end else begin
      case (opcode_of(ir_i))
        ADDI, SUBFI, CMPI, SEQI, SNEI, SLTI:
          imm_o = {{53{ir_i[19]}}, ir_i[19:9]};
        ANDI:
          imm_o = {{53{1'b1}}, ir_i[19:9]};
        ORI, XORI:
          imm_o = {53'd0, ir_i[19:9]};
        ADDIL, CMPIL, SEQIL, SNEIL, SLTIL:
          imm_o = {{41{ir_i[43]}}, ir_i[43:21]};
        ANDIL:
          imm_o = {{41{1'b1}}, ir_i[43:21]};
        ORIL, XORIL:
          imm_o = {41'd0, ir_i[43:21]};
        default:
          imm_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/thor2021_decode_queue.sv
// thor2021_decode_queue
//   Instruction queue between fetch and decode. Buffers fetched instructions,
//   fuses EXI7/EXI23/EXI41 postfixes into a preceding long-immediate
//   instruction and presents one op per cycle through a registered
//   valid/ready output. A lone long-immediate head may wait up to HOLD_MAX
//   cycles for its postfix.
//   Build option: THOR2021_POSTFIX_FUSE_EN enables fusion and hold; without
//   it every entry is emitted singly and postfixes come out as orphans.
//   Parameters: DEPTH (power of two, >= 4), HOLD_MAX.
//   Ports:
//     clk_i, rst_i (sync, active high), flush_i
//     ir_i/pc_i/valid_i/ready_o   fetch side
//     op_o/pc_o/imm_o/ext_o/orphan_o/valid_o/ready_i   decode side
module thor2021_decode_queue
  import thor2021_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  Instruction  ir_i,
  input  logic [63:0] pc_i,
  input  logic        valid_i,
  output logic        ready_o,
  output Instruction  op_o,
  output logic [63:0] pc_o,
  output logic [63:0] imm_o,
  output logic        ext_o,
  output logic        orphan_o,
  output logic        valid_o,
  input  logic        ready_i
);

`ifdef THOR2021_POSTFIX_FUSE_EN
  localparam bit FuseEn = 1'b1;
`else
  localparam bit FuseEn = 1'b0;
`endif

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic [CntW-1:0]  Full    = CntW'(DEPTH);
  localparam logic [HoldW-1:0] HoldLim = HoldW'(HOLD_MAX);

  DecodeQEntry      mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, head_nx;
  logic [CntW-1:0]  count_q, count_d, avail;
  logic [HoldW-1:0] hold_q, hold_d;

  logic        valid_q, valid_d;
  logic        ext_q, ext_d;
  logic        orphan_q, orphan_d;
  Instruction  op_q, op_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] imm_q, imm_d;

  DecodeQEntry in_ent, ent0;
  Instruction  ir1;
  logic        push, out_free, fuse;
  logic        head_long, head_pfx, next_pfx;
  logic [1:0]  pop_n;
  logic [63:0] imm_w;
  HeadAction   act;

  assign ready_o  = !rst_i && (count_q < Full);
  assign push     = valid_i && ready_o;
  assign out_free = !valid_q || ready_i;
  assign in_ent   = '{ir: ir_i, pc: pc_i};
  assign head_nx  = head_q + PtrW'(1);

  // The incoming instruction is visible to classification in the cycle it is
  // pushed, so an empty queue still gives one-cycle latency and a postfix
  // fuses in the cycle it arrives.
  assign avail = count_q + CntW'(push);

  always_comb begin
    ent0 = (count_q != '0) ? mem_q[head_q] : in_ent;
    ir1  = (count_q >= CntW'(2)) ? mem_q[head_nx].ir : ir_i;
  end

  assign head_long = is_long_imm(opcode_of(ent0.ir));
  assign head_pfx  = is_postfix(opcode_of(ent0.ir));
  assign next_pfx  = is_postfix(opcode_of(ir1));

  // Fusion outranks hold expiry: a postfix arriving on the last hold cycle
  // still fuses.
  always_comb begin
    act = ACT_NONE;
    if (avail != '0) begin
      if (head_pfx)
        act = ACT_ORPHAN;
      else if (FuseEn && head_long && (avail >= CntW'(2)) && next_pfx)
        act = ACT_FUSE;
      else if (FuseEn && head_long && (avail == CntW'(1)) && (hold_q < HoldLim))
        act = ACT_WAIT;
      else
        act = ACT_SINGLE;
    end
  end

  assign fuse = (act == ACT_FUSE);

  thor2021_imm_fuse u_imm_fuse (
    .ir_i   (ent0.ir),
    .pfx_i  (ir1),
    .fuse_i (fuse),
    .imm_o  (imm_w)
  );

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    ext_d    = ext_q;
    orphan_d = orphan_q;
    hold_d   = hold_q;
    pop_n    = 2'd0;
    if (out_free) begin
      valid_d = 1'b0;
      case (act)
        ACT_ORPHAN, ACT_SINGLE: begin
          valid_d  = 1'b1;
          op_d     = ent0.ir;
          pc_d     = ent0.pc;
          imm_d    = imm_w;
          ext_d    = 1'b0;
          orphan_d = (act == ACT_ORPHAN);
          pop_n    = 2'd1;
        end
        ACT_FUSE: begin
          valid_d  = 1'b1;
          op_d     = ent0.ir;
          pc_d     = ent0.pc;
          imm_d    = imm_w;
          ext_d    = 1'b1;
          orphan_d = 1'b0;
          pop_n    = 2'd2;
        end
        ACT_WAIT: hold_d = hold_q + HoldW'(1);
        default: ;
      endcase
    end
    if (pop_n != 2'd0) hold_d = '0;
    head_d  = head_q + PtrW'(pop_n);
    tail_d  = tail_q + PtrW'(push);
    count_d = count_q + CntW'(push) - CntW'(pop_n);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= in_ent;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      ext_q    <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      ext_q    <= ext_d;
      orphan_q <= orphan_d;
    end
  end

  assign valid_o  = valid_q;
  assign op_o     = op_q;
  assign pc_o     = pc_q;
  assign imm_o    = imm_q;
  assign ext_o    = ext_q;
  assign orphan_o = orphan_q;

endmodule

// File: tb/tb_thor2021_decode_queue.sv
`timescale 1ns/1ps
module tb_thor2021_decode_queue;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned HOLD_MAX = 4;

`ifdef THOR2021_POSTFIX_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  // ISA encodings (opcode in ir[6:0])
  localparam logic [6:0] OP_ADDI  = 7'h04, OP_SUBFI = 7'h05, OP_CMPI = 7'h06;
  localparam logic [6:0] OP_ANDI  = 7'h08, OP_ORI   = 7'h09, OP_XORI = 7'h0A;
  localparam logic [6:0] OP_SEQI  = 7'h0C, OP_SNEI  = 7'h0D, OP_SLTI = 7'h0E;
  localparam logic [6:0] OP_ADDIL = 7'h14, OP_CMPIL = 7'h16, OP_ANDIL = 7'h18;
  localparam logic [6:0] OP_ORIL  = 7'h19, OP_XORIL = 7'h1A, OP_SEQIL = 7'h1C;
  localparam logic [6:0] OP_SNEIL = 7'h1D, OP_SLTIL = 7'h1E;
  localparam logic [6:0] OP_EXI7  = 7'h48, OP_EXI23 = 7'h49, OP_EXI41 = 7'h4A;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, ready_out, ext, orphan, valid_out, ready_in;
  logic [47:0] ir_in, op_out;
  logic [63:0] pc_in, pc_out, imm_out;

  always #5 clk = ~clk;

  thor2021_decode_queue #(.DEPTH(DEPTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .ir_i     (ir_in),
    .pc_i     (pc_in),
    .valid_i  (valid_in),
    .ready_o  (ready_out),
    .op_o     (op_out),
    .pc_o     (pc_out),
    .imm_o    (imm_out),
    .ext_o    (ext),
    .orphan_o (orphan),
    .valid_o  (valid_out),
    .ready_i  (ready_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [47:0] ir; logic [63:0] pc; } ment_t;
  ment_t       mq[$];
  int          m_hold = 0;
  bit          m_valid = 0, m_ext = 0, m_orphan = 0, m_push;
  logic [47:0] m_op = '0;
  logic [63:0] m_pc = '0, m_imm = '0;

  function automatic bit is_pfx(input logic [47:0] ir);
    return ir[6:0] == OP_EXI7 || ir[6:0] == OP_EXI23 || ir[6:0] == OP_EXI41;
  endfunction

  function automatic bit is_long(input logic [47:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return o == OP_ADDIL || o == OP_CMPIL || o == OP_SEQIL || o == OP_SNEIL ||
           o == OP_SLTIL || o == OP_ANDIL || o == OP_ORIL  || o == OP_XORIL;
  endfunction

  // w-bit value interpreted as two's complement, modulo 2^64
  function automatic logic [63:0] sx(input logic [63:0] v, input int w);
    if (v >= (64'd1 << (w - 1))) return v - (64'd1 << w);
    return v;
  endfunction

  // w-bit value with all upper bits set
  function automatic logic [63:0] ones(input logic [63:0] v, input int w);
    return v - (64'd1 << w);
  endfunction

  function automatic logic [63:0] model_imm(input logic [47:0] ir, input logic [47:0] x,
                                            input bit fused);
    logic [63:0] lo11, hi23;
    logic [6:0]  o;
    lo11 = 64'(ir[19:9]);
    hi23 = 64'(ir[43:21]);
    o    = ir[6:0];
    if (fused) begin
      if (x[6:0] == OP_EXI7)  return sx(64'(x[15:9]) * 64'd8388608 + hi23, 30);
      if (x[6:0] == OP_EXI23) return sx(64'(x[31:9]) * 64'd8388608 + hi23, 46);
      return 64'(x[47:9]) * 64'd33554432 + hi23 * 64'd4 + 64'(x[1:0]);
    end
    if (o == OP_ADDI || o == OP_SUBFI || o == OP_CMPI || o == OP_SEQI ||
        o == OP_SNEI || o == OP_SLTI) return sx(lo11, 11);
    if (o == OP_ANDI) return ones(lo11, 11);
    if (o == OP_ORI || o == OP_XORI) return lo11;
    if (o == OP_ANDIL) return ones(hi23, 23);
    if (o == OP_ORIL || o == OP_XORIL) return hi23;
    if (is_long(ir)) return sx(hi23, 23);
    return 64'd0;
  endfunction

  task automatic m_emit(input bit fused, input bit orph);
    m_valid  = 1'b1;
    m_op     = mq[0].ir;
    m_pc     = mq[0].pc;
    m_imm    = orph ? 64'd0 : model_imm(mq[0].ir, fused ? mq[1].ir : 48'd0, fused);
    m_ext    = fused;
    m_orphan = orph;
    void'(mq.pop_front());
    if (fused) void'(mq.pop_front());
    m_hold = 0;
  endtask

  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      m_hold = 0;
      m_valid = 1'b0; m_op = '0; m_pc = '0; m_imm = '0; m_ext = 1'b0; m_orphan = 1'b0;
    end else begin
      m_push = valid_in && (mq.size() < DEPTH);
      if (m_push) mq.push_back('{ir: ir_in, pc: pc_in});
      if (!m_valid || ready_in) begin
        m_valid = 1'b0;
        if (mq.size() > 0) begin
          if (is_pfx(mq[0].ir))
            m_emit(1'b0, 1'b1);
          else if (FUSE && is_long(mq[0].ir) && mq.size() >= 2 && is_pfx(mq[1].ir))
            m_emit(1'b1, 1'b0);
          else if (FUSE && is_long(mq[0].ir) && mq.size() == 1 && m_hold < int'(HOLD_MAX))
            m_hold++;
          else
            m_emit(1'b0, 1'b0);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("valid_o", 64'(valid_out), 64'(m_valid));
    chk("ready_o", 64'(ready_out), 64'(!rst && mq.size() < DEPTH));
    if (m_valid) begin
      chk("op_o", 64'(op_out), 64'(m_op));
      chk("pc_o", pc_out, m_pc);
      chk("imm_o", imm_out, m_imm);
      chk("ext_o", 64'(ext), 64'(m_ext));
      chk("orphan_o", 64'(orphan), 64'(m_orphan));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [47:0] mk_op(input logic [6:0] op, input logic [10:0] lo,
                                        input logic [22:0] hi);
    logic [47:0] r;
    r = '0;
    r[6:0]   = op;
    r[19:9]  = lo;
    r[43:21] = hi;
    return r;
  endfunction

  function automatic logic [47:0] mk_pf(input logic [6:0] op, input logic [38:0] x);
    logic [47:0] r;
    r = '0;
    r[47:9] = x;
    r[6:0]  = op;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] ir, input logic [63:0] pc);
    valid_in = 1'b1;
    ir_in    = ir;
    pc_in    = pc;
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ir_in = '0; pc_in = '0; ready_in = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_op", 64'(op_out), 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_imm", imm_out, 64'd0);
    chk("rst_ext", 64'(ext), 64'd0);
    chk("rst_orphan", 64'(orphan), 64'd0);
    rst = 1'b0;
    ready_in = 1'b1;
    tick();

    // ADDI with all-ones short immediate: one-cycle latency, sign-extended
    push(mk_op(OP_ADDI, 11'h7FF, 23'h0), 64'h100);
    chk("addi_valid", 64'(valid_out), 64'd1);
    chk("addi_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ext", 64'(ext), 64'd0);
    tick();

    // ADDIL followed by EXI23
    push(mk_op(OP_ADDIL, 11'h0, 23'h000001), 64'h200);
    push(mk_pf(OP_EXI23, 39'h400000), 64'h206);
`ifdef THOR2021_POSTFIX_FUSE_EN
    chk("fuse23_valid", 64'(valid_out), 64'd1);
    chk("fuse23_ext", 64'(ext), 64'd1);
    chk("fuse23_imm", imm_out, 64'hFFFF_E000_0000_0001);
    chk("fuse23_pc", pc_out, 64'h200);
`else
    chk("exi23_orphan", 64'(orphan), 64'd1);
    chk("exi23_imm", imm_out, 64'd0);
    chk("exi23_pc", pc_out, 64'h206);
`endif
    tick();
    tick();

    // ORIL alone: waits HOLD_MAX cycles, then zero-padded immediate
    push(mk_op(OP_ORIL, 11'h0, 23'h4ABCDE), 64'h300);
`ifdef THOR2021_POSTFIX_FUSE_EN
    for (int i = 0; i < 4; i++) begin
      chk("hold_wait", 64'(valid_out), 64'd0);
      tick();
    end
`endif
    chk("oril_valid", 64'(valid_out), 64'd1);
    chk("oril_ext", 64'(ext), 64'd0);
    chk("oril_imm", imm_out, 64'h0000_0000_004A_BCDE);
    tick();
    tick();

    // Postfix at an empty queue
    push(mk_pf(OP_EXI7, 39'h55), 64'h400);
    chk("orphan_valid", 64'(valid_out), 64'd1);
    chk("orphan_flag", 64'(orphan), 64'd1);
    chk("orphan_imm", imm_out, 64'd0);
    tick();

    // Postfix arriving in the hold-expiry cycle still fuses
    push(mk_op(OP_ADDIL, 11'h0, 23'h123456), 64'h500);
    tick();
    tick();
    tick();
    push(mk_pf(OP_EXI41, 39'h40_0000_0003), 64'h506);
`ifdef THOR2021_POSTFIX_FUSE_EN
    chk("fuse41_ext", 64'(ext), 64'd1);
    chk("fuse41_imm", imm_out, 64'h8000_0000_0648_D15A);
`else
    chk("exi41_orphan", 64'(orphan), 64'd1);
`endif
    tick();
    tick();

    // Fill with downstream stalled; pointers wrap
    ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(mk_op(OP_ADDI, 11'(i + 1), 23'h0), 64'h1000 + 64'(i) * 64'd4);
      if (i == 7) chk("fill_ready_7", 64'(ready_out), 64'd1);
      if (i == 8) chk("fill_ready_full", 64'(ready_out), 64'd0);
    end
    chk("stall_pc", pc_out, 64'h1000);
    // Push while full and popping: must be dropped
    valid_in = 1'b1;
    ir_in    = mk_op(OP_ADDI, 11'h3AA, 23'h0);
    pc_in    = 64'hDEAD;
    ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("drain_pc1", pc_out, 64'h1004);
    repeat (12) tick();
    chk("drained_valid", 64'(valid_out), 64'd0);

    // Flush with a simultaneous push
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push(mk_op(OP_ADDI, 11'h11, 23'h0), 64'h2000 + 64'(i) * 64'd4);
    valid_in = 1'b1;
    ir_in    = mk_op(OP_ADDI, 11'h22, 23'h0);
    pc_in    = 64'h2FF0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    chk("flush_valid", 64'(valid_out), 64'd0);
    ready_in = 1'b1;
    repeat (3) tick();
    push(mk_op(OP_XORI, 11'h7F0, 23'h0), 64'h3000);
    chk("post_flush_pc", pc_out, 64'h3000);
    chk("post_flush_imm", imm_out, 64'h0000_0000_0000_07F0);
    tick();

    // Reset in mid-operation
    ready_in = 1'b0;
    push(mk_op(OP_ANDI, 11'h001, 23'h0), 64'h4000);
    push(mk_op(OP_ADDI, 11'h002, 23'h0), 64'h4004);
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(ready_out), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_pc", pc_out, 64'd0);
    rst = 1'b0;
    tick();
    ready_in = 1'b1;
    push(mk_op(OP_ANDI, 11'h001, 23'h0), 64'h5000);
    chk("andi_imm", imm_out, 64'hFFFF_FFFF_FFFF_F801);
    chk("andi_pc", pc_out, 64'h5000);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thor2021_decode_queue.md
# thor2021_decode_queue

Parametrised instruction decode queue between fetch and the decoder/issue stage. Buffers fetched instructions, fuses immediate-extension postfixes (EXI7/EXI23/EXI41) into the preceding instruction, and presents one fused op per cycle with a registered valid/ready handshake. Long-immediate instructions are held for a bounded number of cycles so that a late-arriving postfix can still be fused.

## Interface
- DEPTH, 8: queue entries; power of two, minimum 4.
- HOLD_MAX, 4: cycles a long-immediate head waits for a postfix before it is emitted unextended; 0 disables waiting.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all queued and output state.
- ir_i  in  48  fetched instruction (Instruction).
- pc_i  in  64  address of ir_i.
- valid_i  in  1  ir_i/pc_i valid.
- ready_o  out  1  queue accepts this cycle.
- op_o  out  48  head instruction.
- pc_o  out  64  head address.
- imm_o  out  64  fused immediate, or the sign/zero-extended short form.
- ext_o  out  1  postfix consumed (op spans two slots).
- orphan_o  out  1  op is a postfix with no predecessor; treat as NOP.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream accepts.

## Operation
- Push when valid_i && ready_o. ready_o = !rst_i && count < DEPTH. Pop and push can coincide; a push is never accepted while full, even if a pop occurs that cycle.
- Head classification, evaluated when the output register is free or is being drained (!valid_o || ready_i):
  - Head is a postfix: emit orphan_o=1, imm_o=0, pop 1.
  - Head is long-immediate (ADDIL, CMPIL, SEQIL, SNEIL, SLTIL, ANDIL, ORIL, XORIL) and entry head+1 is a postfix: fuse, ext_o=1, pop 2.
  - Head is long-immediate, count==1, hold counter < HOLD_MAX: wait and increment the hold counter.
  - Otherwise emit head alone, ext_o=0, pop 1.
- The hold counter clears on every pop, on flush and on reset.
- Fused immediate, where ir is the head and x is the postfix:
  - EXI7: sign-extend {x[15:9], ir[43:21]} to 64.
  - EXI23: sign-extend {x[31:9], ir[43:21]} to 64.
  - EXI41: {x[47:9], ir[43:21], x[1:0]}.
- Unextended immediates:
  - ADDI, SUBFI, CMPI, SEQI, SNEI, SLTI: sign-extend ir[19:9].
  - ANDI: ones-pad ir[19:9].
  - ORI, XORI: zero-pad ir[19:9].
  - Long forms: sign-extend ir[43:21] (ANDIL ones-pad, ORIL/XORIL zero-pad).
  - All other opcodes: 0.
- A postfix following a non-long-immediate instruction is not fused; it later reaches the head and is emitted as an orphan.

## Timing
- Reset values: valid_o=0, ready_o=0, ext_o=0, orphan_o=0, op_o=0, pc_o=0, imm_o=0, count=0, head and tail pointers 0, hold counter 0.
- Latency: the instruction pushed in cycle N is on the outputs in cycle N+1 when the queue is empty and no hold applies.
- A fused pair needs both slots present. If the postfix is pushed in cycle N, the fused op is valid in cycle N+1.
- Output stall: while valid_o && !ready_i, all outputs hold their values and no pop occurs.
- flush_i has priority over push, pop and output update. Next cycle: valid_o=0, count=0; the push in the flush cycle is dropped.
- Reset asserted mid-operation behaves the same as flush, and ready_o is also held low.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Hold expiry: a head that has waited HOLD_MAX cycles is emitted unextended in the following cycle. A postfix arriving in that same cycle is still fused, because fusion takes priority over expiry.

## Configuration
- THOR2021_POSTFIX_FUSE_EN defined: postfix fusion and the hold logic are as described above.
- Undefined: no fusion and no hold. Every entry pops singly, ext_o is tied to 0, and postfixes are emitted with orphan_o=1. HOLD_MAX is ignored.

## Structure
- Thor2021_pkg holds:
  - the EXI7/EXI23/EXI41 and long-immediate opcode constants;
  - the Instruction type;
  - a new typedef DecodeQEntry {Instruction ir; logic [63:0] pc;};
  - a function is_long_imm(opcode).
- One sub-module, thor2021_imm_fuse: combinational. Takes (head ir, postfix ir, fuse flag) and returns the 64-bit imm_o. Instantiated once.

## Test plan
- Push ADDI with ir[19:9]=11'h7FF, ready_i=1 -> next cycle valid_o=1, imm_o=64'hFFFF_FFFF_FFFF_FFFF, ext_o=0.
- Push ADDIL with ir[43:21]=23'h000001, then EXI23 with x[31:9]=23'h400000 in consecutive cycles -> one op, ext_o=1, imm_o=64'hFFFF_E000_0000_0001.
- Push ORIL alone, HOLD_MAX=4, no further pushes -> valid_o stays 0 for 4 cycles, then the op appears with ext_o=0 and imm_o zero-extended.
- Push EXI7 at an empty queue -> orphan_o=1, imm_o=0.
- Fill DEPTH=8 entries with ready_i=0 -> ready_o=0 after the 8th push. Then ready_i=1 -> ready_o rises once count falls below 8, and FIFO order is preserved across pointer wrap.
- Assert flush_i in the same cycle as valid_i with the queue half full -> next cycle valid_o=0, count=0; the pushed instruction never appears.
